// File: rtl/rvfi_retire_serializer_if.sv
// Retire-serializer bus: multi-channel retire input side plus single-entry head output side.
interface rvfi_retire_serializer_if #(
  parameter int unsigned NRET  = 1,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  logic [NRET-1:0]                in_valid;
  logic [NRET*8-1:0]              in_order;
  logic [NRET*32-1:0]             in_insn;
  logic [NRET*XLEN-1:0]           in_pc;
  logic                           in_ready;
  logic                           out_valid;
  logic                           out_ready;
  logic [7:0]                     out_order;
  logic [31:0]                    out_insn;
  logic [XLEN-1:0]                out_pc;
  logic [$clog2(DEPTH+1)-1:0]     count;
  logic                           overflow;
  logic                           order_error;

  modport master (
    output in_valid, in_order, in_insn, in_pc, out_ready,
    input  in_ready, out_valid, out_order, out_insn, out_pc, count, overflow, order_error
  );

  modport slave (
    input  in_valid, in_order, in_insn, in_pc, out_ready,
    output in_ready, out_valid, out_order, out_insn, out_pc, count, overflow, order_error
  );
endinterface

// File: rtl/rvfi_retire_serializer.sv
// Compacts up to NRET retirements per cycle into a FWFT queue drained one entry per cycle.
// Optional order checking: define RISCV_FORMAL_SERIALIZER_ORDERCHK_EN.
module rvfi_retire_serializer #(
  parameter int unsigned NRET  = 1,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  rvfi_retire_serializer_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]      r_order [DEPTH];
  logic [31:0]     r_insn  [DEPTH];
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;

  logic            w_ready;
  logic            w_any;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic [CW-1:0]   w_nvalid;
  logic [PW-1:0]   w_slot [NRET];

  // in_ready depends only on the registered count, so a same-cycle pop never opens space
  assign w_ready = (32'(r_count) + NRET) <= DEPTH;
  assign w_any   = |bus.in_valid;
  assign w_push  = w_any && w_ready;
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && bus.out_ready;

  // Each valid channel lands at write pointer + number of valid channels below it
  always_comb begin
    w_nvalid = '0;
    for (int unsigned i = 0; i < NRET; i++) begin
      w_slot[i] = r_wptr + PW'(w_nvalid);
      w_nvalid  = w_nvalid + CW'(bus.in_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      for (int unsigned i = 0; i < NRET; i++) begin
        if (bus.in_valid[i]) begin
          r_order[w_slot[i]] <= bus.in_order[i*8 +: 8];
          r_insn[w_slot[i]]  <= bus.in_insn[i*32 +: 32];
          r_pc[w_slot[i]]    <= bus.in_pc[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(w_nvalid);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= r_count + (w_push ? w_nvalid : '0) - CW'(w_pop);
      if (w_any && !w_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_order = w_valid ? r_order[r_rptr] : '0;
  assign bus.out_insn  = w_valid ? r_insn[r_rptr]  : '0;
  assign bus.out_pc    = w_valid ? r_pc[r_rptr]    : '0;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;

`ifdef RISCV_FORMAL_SERIALIZER_ORDERCHK_EN
  logic       r_base_valid;
  logic [7:0] r_prev_order;
  logic       r_order_error;

  // The first dequeue after reset only establishes the baseline
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base_valid  <= 1'b0;
      r_prev_order  <= '0;
      r_order_error <= 1'b0;
    end else if (w_pop) begin
      if (r_base_valid && (r_order[r_rptr] != r_prev_order + 8'd1)) begin
        r_order_error <= 1'b1;
      end
      r_prev_order <= r_order[r_rptr];
      r_base_valid <= 1'b1;
    end
  end

  assign bus.order_error = r_order_error;
`else
  assign bus.order_error = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Self-checking bench for rvfi_retire_serializer (NRET=2, DEPTH=4, XLEN=32) against a queue model.
module tb_rvfi_retire_serializer;
  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef RISCV_FORMAL_SERIALIZER_ORDERCHK_EN
  localparam bit ORDCHK = 1'b1;
`else
  localparam bit ORDCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rvfi_retire_serializer_if #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  rvfi_retire_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  o;
    logic [31:0] i;
    logic [31:0] p;
  } ent_t;

  ent_t       mq[$];
  bit         m_ovf;
  bit         m_oerr;
  bit         m_base;
  logic [7:0] m_prev;

  // Drive one cycle of stimulus and advance the reference model across the clock edge.
  task automatic cycle(input logic [1:0] v, input logic [15:0] ord, input logic [63:0] insn,
                       input logic [63:0] pc, input logic rdy);
    bit   acc;
    ent_t e;
    bus.in_valid  = v;
    bus.in_order  = ord;
    bus.in_insn   = insn;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    acc = (mq.size() + NRET) <= DEPTH;
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_oerr = 0; m_base = 0; m_prev = '0;
    end else begin
      if (mq.size() != 0 && rdy) begin
        e = mq.pop_front();
        if (m_base && e.o != m_prev + 8'd1) m_oerr = 1;
        m_prev = e.o;
        m_base = 1;
      end
      if (v != 2'b00) begin
        if (acc) begin
          for (int c = 0; c < NRET; c++) begin
            if (v[c]) begin
              e.o = ord[c*8 +: 8];
              e.i = insn[c*32 +: 32];
              e.p = pc[c*32 +: 32];
              mq.push_back(e);
            end
          end
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(2'b00, '0, '0, '0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(2'b11, 16'h0201, 64'h1, 64'h2, 1'b1);
    cycle(2'b00, '0, '0, '0, 1'b0);
    reset = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    checks++; if (bus.order_error !== 1'b0) begin errors++; $display("FAIL reset_order_error: got %b expected 0", bus.order_error); end
    checks++; if ({bus.out_order, bus.out_insn, bus.out_pc} !== 72'd0) begin errors++;
      $display("FAIL reset_out_fields: got %h/%h/%h expected 0", bus.out_order, bus.out_insn, bus.out_pc); end
  endtask

  task automatic test_dual_push();
    logic [7:0] exp_o [2];
    exp_o[0] = 8'd5; exp_o[1] = 8'd6;
    do_reset();
    cycle(2'b11, {8'd6, 8'd5}, {32'hB, 32'hA}, {32'h1004, 32'h1000}, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.count !== 3'(2 - k)) begin errors++; $display("FAIL dual_count[%0d]: got %0d expected %0d", k, bus.count, 2 - k); end
      if (k < 2) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_order !== exp_o[k]) begin errors++;
          $display("FAIL dual_head[%0d]: got v=%b o=%0d expected v=1 o=%0d", k, bus.out_valid, bus.out_order, exp_o[k]); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dual_drained: got %b expected 0", bus.out_valid); end
      end
      cycle(2'b00, '0, '0, '0, 1'b1);
    end
  endtask

  task automatic test_sparse();
    do_reset();
    cycle(2'b10, {8'd9, 8'd77}, {32'h0000_0013, 32'hDEAD}, {32'h100, 32'h200}, 1'b0);
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL sparse_count: got %0d expected 1", bus.count); end
    checks++; if (bus.out_order !== 8'd9 || bus.out_pc !== 32'h100 || bus.out_insn !== 32'h13) begin errors++;
      $display("FAIL sparse_head: got o=%0d pc=%h insn=%h expected o=9 pc=100 insn=13", bus.out_order, bus.out_pc, bus.out_insn); end
  endtask

  task automatic test_overflow();
    do_reset();
    cycle(2'b11, {8'd2, 8'd1}, {32'h22, 32'h11}, {32'h8, 32'h4}, 1'b0);
    cycle(2'b11, {8'd4, 8'd3}, {32'h44, 32'h33}, {32'h10, 32'hC}, 1'b0);
    checks++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL full_state: got count=%0d in_ready=%b expected 4/0", bus.count, bus.in_ready); end
    cycle(2'b11, {8'd6, 8'd5}, {32'h66, 32'h55}, {32'h18, 32'h14}, 1'b0);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b expected 1", bus.overflow); end
    checks++; if (bus.count !== 3'd4 || bus.out_order !== 8'd1 || bus.out_insn !== 32'h11) begin errors++;
      $display("FAIL overflow_hold: got count=%0d o=%0d expected 4/1", bus.count, bus.out_order); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cycle(2'b11, {8'd2, 8'd1}, '0, '0, 1'b0);
    cycle(2'b11, {8'd4, 8'd3}, '0, '0, 1'b1);
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL simul_count: got %0d expected 3", bus.count); end
    checks++; if (bus.out_order !== 8'd2) begin errors++; $display("FAIL simul_head: got %0d expected 2", bus.out_order); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    cycle(2'b11, {8'd2, 8'd1}, '0, '0, 1'b0);
    cycle(2'b01, {8'd0, 8'd3}, '0, '0, 1'b0);
    cycle(2'b11, {8'd5, 8'd4}, '0, '0, 1'b0);
    checks++; if (bus.count !== 3'd3 || bus.overflow !== 1'b1) begin errors++;
      $display("FAIL pre_reset: got count=%0d ovf=%b expected 3/1", bus.count, bus.overflow); end
    reset = 1'b1;
    cycle(2'b11, {8'd7, 8'd6}, '0, '0, 1'b1);
    reset = 1'b0;
    checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b0) begin errors++;
      $display("FAIL mid_reset: got count=%0d v=%b ovf=%b expected 0/0/0", bus.count, bus.out_valid, bus.overflow); end
  endtask

  task automatic test_order();
    do_reset();
    cycle(2'b11, {8'd7, 8'd5}, '0, '0, 1'b0);
    cycle(2'b00, '0, '0, '0, 1'b1);
    checks++; if (bus.order_error !== 1'b0) begin errors++; $display("FAIL order_baseline: got %b expected 0", bus.order_error); end
    cycle(2'b00, '0, '0, '0, 1'b1);
    checks++; if (bus.order_error !== ORDCHK) begin errors++; $display("FAIL order_gap: got %b expected %b", bus.order_error, ORDCHK); end
    do_reset();
    cycle(2'b11, {8'd0, 8'd255}, '0, '0, 1'b0);
    cycle(2'b00, '0, '0, '0, 1'b1);
    cycle(2'b00, '0, '0, '0, 1'b1);
    checks++; if (bus.order_error !== 1'b0) begin errors++; $display("FAIL order_wrap: got %b expected 0", bus.order_error); end
  endtask

  task automatic test_random();
    logic [7:0]  nxt;
    logic [1:0]  v;
    logic [15:0] ord;
    logic [63:0] insn, pc;
    do_reset();
    nxt = 8'($urandom);
    for (int n = 0; n < 400; n++) begin
      v = 2'($urandom);
      for (int c = 0; c < NRET; c++) begin
        if ($urandom_range(15) == 0) nxt = nxt + 8'd1;
        ord[c*8 +: 8] = nxt;
        if (v[c]) nxt = nxt + 8'd1;
      end
      insn = {$urandom, $urandom};
      pc   = {$urandom, $urandom};
      cycle(v, ord, insn, pc, $urandom_range(9) < 7);
      checks++;
      if (bus.count !== 3'(mq.size()) || bus.in_ready !== (mq.size() + NRET <= DEPTH) ||
          bus.overflow !== m_ovf || bus.order_error !== (ORDCHK & m_oerr)) begin
        errors++;
        $display("FAIL rand_status[%0d]: got cnt=%0d rdy=%b ovf=%b oe=%b expected cnt=%0d ovf=%b oe=%b",
                 n, bus.count, bus.in_ready, bus.overflow, bus.order_error, mq.size(), m_ovf, ORDCHK & m_oerr);
      end
      if (mq.size() != 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_order !== mq[0].o || bus.out_insn !== mq[0].i || bus.out_pc !== mq[0].p) begin
          errors++;
          $display("FAIL rand_head[%0d]: got v=%b %h/%h/%h expected %h/%h/%h", n, bus.out_valid,
                   bus.out_order, bus.out_insn, bus.out_pc, mq[0].o, mq[0].i, mq[0].p);
        end
      end else begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_order !== 8'd0 || bus.out_pc !== 32'd0) begin
          errors++;
          $display("FAIL rand_empty[%0d]: got v=%b o=%h pc=%h expected 0", n, bus.out_valid, bus.out_order, bus.out_pc);
        end
      end
    end
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_order  = '0;
    bus.in_insn   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_dual_push();
    test_sparse();
    test_overflow();
    test_simultaneous();
    test_reset_midstream();
    test_order();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rvfi_retire_serializer.md
RVFI_RETIRE_SERIALIZER -- requirements
Module: rvfi_retire_serializer

Interface
REQ-001 SHALL have parameter NRET, default 1: number of retire channels in.
REQ-002 SHALL have parameter XLEN, default 32: PC width.
REQ-003 SHALL have parameter DEPTH, default 4: queue entries; power of two, >= NRET.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  NRET  per-channel retire valid.
REQ-007 SHALL have port in_order  input  NRET*8  per-channel retire order, channel i at [i*8 +: 8].
REQ-008 SHALL have port in_insn  input  NRET*32  per-channel instruction word.
REQ-009 SHALL have port in_pc  input  NRET*XLEN  per-channel pre-PC.
REQ-010 SHALL have port in_ready  output  1  high when free entries >= NRET.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head.
REQ-013 SHALL have ports out_order (8), out_insn (32), out_pc (XLEN), all outputs: head entry fields.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.
REQ-015 SHALL have port overflow  output  1  sticky: retirement dropped.
REQ-016 SHALL have port order_error  output  1  sticky order-sequence violation (see Configuration).

Function
REQ-017 SHALL compute in_ready combinationally from registered count only, never from same-cycle dequeue.
REQ-018 SHALL, when in_ready and any in_valid bit set, enqueue all valid channels in one cycle, lower channel index first, compacted; non-contiguous valid bits are legal.
REQ-019 SHALL, when any in_valid bit set and in_ready low, drop all that cycle's channels, leave queue unchanged, set overflow.
REQ-020 SHALL drive out_valid = (count != 0) and out_* from head storage (first-word fall-through); enqueue into empty queue is visible on out_valid next cycle.
REQ-021 SHALL dequeue head on out_valid && out_ready.
REQ-022 SHALL hold out_* stable while out_valid && !out_ready.
REQ-023 SHALL, on simultaneous enqueue of n and dequeue, update count to count + n - 1 in one cycle.
REQ-024 SHALL wrap read/write pointers modulo DEPTH with no dead entry; full means count == DEPTH.
REQ-025 SHALL ignore out_ready while out_valid low.

Reset
REQ-026 SHALL on reset clear pointers, count=0, out_valid=0, overflow=0, order_error=0, order baseline invalid; reset overrides simultaneous enqueue/dequeue.
REQ-027 SHALL drive out_order/out_insn/out_pc as 0 while out_valid low after reset.

Configuration
REQ-028 SHALL compile order checking in only when RISCV_FORMAL_SERIALIZER_ORDERCHK_EN is defined.
REQ-029 With the macro: first dequeue after reset sets baseline; each later dequeue with out_order != previous + 1 (mod 256) SHALL set order_error.
REQ-030 Without the macro: order_error SHALL be tied 0 and no baseline state SHALL exist.

Verification (NRET=2, DEPTH=4, XLEN=32)
REQ-031 in_valid=2'b11, orders 5,6, out_ready=1 -> out_order 5 next cycle, then 6; count 2,1,0.
REQ-032 in_valid=2'b10, ch1 order 9 pc 0x100 -> single entry, out_order 9, out_pc 0x100, count 1.
REQ-033 out_ready=0, two pushes of 2'b11 -> count 4, in_ready 0; third push -> overflow 1, count stays 4, head unchanged.
REQ-034 count=2, push 2'b11 with out_ready=1 -> count 3 next cycle, head advances one entry.
REQ-035 reset asserted at count=3 with push pending -> next cycle count 0, out_valid 0, overflow 0.
REQ-036 dequeue orders 5 then 7 -> order_error 1 with macro defined, 0 without.
